// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state and command types for the data-memory arbiter
package dmem_arb_pkg;
  localparam int DMEM_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
  typedef struct packed {
    logic owner;
    logic we;
    logic err;
    logic [DMEM_W-1:0] addr;
    logic [DMEM_W-1:0] wdata;
  } arb_cmd_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant, one-hot or zero
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       en,
  output logic [1:0] gnt
);
  assign gnt[0] = en && req[0] && (!req[1] || !prio);
  assign gnt[1] = en && req[1] && (!req[0] || prio);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sequencer sharing one data_memory between two requesters
module dmem_arbiter #(
  parameter int W = 32,
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  input  logic [1:0]   req_we,
  input  logic [W-1:0] req_addr0,
  input  logic [W-1:0] req_addr1,
  input  logic [W-1:0] req_wdata0,
  input  logic [W-1:0] req_wdata1,
  output logic [1:0]   req_ready,
  output logic [1:0]   rsp_valid,
  output logic         rsp_err,
  output logic [W-1:0] rsp_rdata,
  output logic         MemRead,
  output logic         MemWrite,
  output logic [W-1:0] mem_address,
  output logic [W-1:0] mem_write_data,
  input  logic [W-1:0] mem_read_data
);
  import dmem_arb_pkg::*;
  arb_state_t state, state_n;
  arb_cmd_t cmd;
  logic prio;
  logic owner;
  logic [1:0] gnt;
  logic [W-1:0] addr_in;
  rr_arbiter_2 u_rr (.req(req_valid), .prio(prio), .en(state == IDLE && !rst), .gnt(gnt));
  assign req_ready = gnt;
  assign owner = gnt[1];
  assign addr_in = owner ? req_addr1 : req_addr0;
  always_comb begin
    state_n = IDLE;
    if (state == IDLE) state_n = |gnt ? ISSUE : IDLE;
    if (state == ISSUE) state_n = RESP;
    MemRead = state == ISSUE && !cmd.err && !cmd.we;
    MemWrite = state == ISSUE && !cmd.err && cmd.we;
    mem_address = (MemRead || MemWrite) ? cmd.addr : '0;
    mem_write_data = MemWrite ? cmd.wdata : '0;
    rsp_valid = state == RESP ? (cmd.owner ? 2'b10 : 2'b01) : 2'b00;
    rsp_err = state == RESP && cmd.err;
    rsp_rdata = (state == RESP && !cmd.we && !cmd.err) ? mem_read_data : '0;
  end
  // Range check uses every upper address bit so large addresses never alias into memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prio <= 1'b0;
      cmd <= '0;
    end else begin
      state <= state_n;
      if (|gnt) begin
        cmd <= '{owner: owner, we: req_we[owner], err: (addr_in >> N) != '0,
                 addr: addr_in, wdata: owner ? req_wdata1 : req_wdata0};
        prio <= ~owner;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench with a registered-read memory model behind the arbiter
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req_valid = '0, req_we = '0;
  logic [31:0] req_addr0 = '0, req_addr1 = '0, req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0] req_ready, rsp_valid;
  logic rsp_err, MemRead, MemWrite;
  logic [31:0] rsp_rdata, mem_address, mem_write_data;
  logic [31:0] mem_read_data = '0;
  int checks = 0, errors = 0;

  typedef struct {logic [1:0] owner; logic err; logic [31:0] rdata;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] mem [0:31];
  logic [31:0] sm [0:31];
  logic mem_ok = 1'b0, sm_ok = 1'b0;
  logic s1v = 1'b0, s1we = 1'b0, s1err = 1'b0, s2v = 1'b0, exp_prio = 1'b0;
  logic [31:0] s1a = '0, s1d = '0, a, d;
  logic [1:0] hs, eg;
  logic o, w, er;

  dmem_arbiter #(.W(32), .N(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] iv(input int i);
    return 32'h5A00_0000 + i;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!mem_ok) begin
      for (int i = 0; i < 32; i++) mem[i] <= iv(i);
      mem_ok <= 1'b1;
    end
    if (MemWrite) mem[mem_address[4:0]] <= mem_write_data;
    if (MemRead) mem_read_data <= mem[mem_address[4:0]];
  end

  // Reference model: tracks FSM phase, round-robin priority and memory contents.
  always @(negedge clk) begin
    if (rst) begin
      if (!sm_ok) for (int i = 0; i < 32; i++) sm[i] = iv(i);
      sm_ok = 1'b1;
      q.delete();
      s1v = 1'b0;
      s2v = 1'b0;
      exp_prio = 1'b0;
    end else begin
      chk("mem_read", MemRead, s1v && !s1we && !s1err);
      chk("mem_write", MemWrite, s1v && s1we && !s1err);
      chk("mem_addr", mem_address, (s1v && !s1err) ? s1a : 32'h0);
      chk("mem_wdata", mem_write_data, (s1v && s1we && !s1err) ? s1d : 32'h0);
      if (s1v && s1we && !s1err) sm[s1a[4:0]] = s1d;
      chk("rsp_timing", rsp_valid != 2'b00, s2v);
      if (rsp_valid != 2'b00) begin
        if (q.size() == 0) chk("rsp_unexpected", rsp_valid, 2'b00);
        else begin
          e = q.pop_front();
          chk("rsp_owner", rsp_valid, e.owner);
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
      eg = (s1v || s2v) ? 2'b00 : (req_valid == 2'b11) ? (exp_prio ? 2'b10 : 2'b01) : req_valid;
      chk("req_ready", req_ready, eg);
      s2v = s1v;
      s1v = 1'b0;
      hs = req_valid & req_ready;
      if (hs != 2'b00) begin
        o = hs[1];
        a = o ? req_addr1 : req_addr0;
        d = o ? req_wdata1 : req_wdata0;
        w = req_we[o];
        er = a >= 32;
        s1v = 1'b1; s1we = w; s1err = er; s1a = a; s1d = d;
        q.push_back('{o ? 2'b10 : 2'b01, er, (!w && !er) ? sm[a[4:0]] : 32'h0});
        exp_prio = ~o;
      end
    end
  end

  task automatic req(input int p, input logic we, input logic [31:0] ad, input logic [31:0] wd);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    req_valid[p] = 1'b1;
    req_we[p] = we;
    if (p == 1) begin req_addr1 = ad; req_wdata1 = wd; end
    else begin req_addr0 = ad; req_wdata0 = wd; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req_ready[p];
    end
    chk("hs_timeout", got, 1'b1);
    @(posedge clk); #1 req_valid[p] = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {req_ready, rsp_valid, rsp_err, MemRead, MemWrite}, 0);
    chk(tag, mem_address | mem_write_data | rsp_rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_zero("reset_outs");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 req_valid = 2'b01; req_we = 2'b01; req_addr0 = 32'd3; req_wdata0 = 32'hCAFE_0003;
    @(negedge clk) chk("t1_ready", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    chk("t1_issue_wr", MemWrite, 1'b1);
    #1 rst = 1'b1;
    #1 chk_zero("t1_async_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    chk("t1_mem3", mem[3], iv(3));
    req(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    req(0, 1'b0, 32'd5, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    req_we = 2'b00; req_addr0 = 32'd1; req_addr1 = 32'd2; req_valid = 2'b11;
    repeat (14) @(posedge clk);
    #1 req_valid = 2'b00;
    repeat (4) @(posedge clk);
    req(0, 1'b0, 32'd31, 32'h0);
    req(1, 1'b0, 32'd32, 32'h0);
    req(0, 1'b1, 32'h40, 32'h5555_5555);
    req(1, 1'b1, 32'h8000_0005, 32'h7777_7777);
    req(1, 1'b1, 32'd7, 32'h1234);
    req(0, 1'b0, 32'd7, 32'h0);
    req(1, 1'b0, 32'd5, 32'h0);
    repeat (4) @(posedge clk);
    chk("q_empty", q.size(), 0);
    for (int i = 0; i < 32; i++) chk("mem_final", mem[i], sm[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
